// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with runtime-programmable almost-full / almost-empty
//   watermarks, an exact fill level, sticky overflow / underflow flags and a
//   synchronous flush. FWFT selects registered-read (0) or first-word-fall-
//   through (1) output behaviour. Storage depth is 2^AW words of DW bits.
//
// Parameters
//   DW      data width
//   AW      address width, depth = 2^AW (AW >= 2)
//   FWFT    0: o_dat loads the popped word one cycle after an accepted read
//           1: o_dat shows the head word whenever the FIFO is not empty
//   AF_RST  reference almost-full threshold; informational, not loaded
//
// Ports
//   clk           rising-edge clock for all logic
//   rstn          synchronous active-low reset (storage is not cleared)
//   w_en / i_dat  write request and data, accepted when not full
//   r_en          pop request, accepted when not empty
//   o_dat         read data
//   flush         empties the FIFO, overrides w_en / r_en in that cycle
//   af_thresh     almost-full threshold in words
//   ae_thresh     almost-empty threshold in words
//   count         fill level 0..2^AW
//   full / empty  count == 2^AW / count == 0
//   almost_full   count >= af_thresh
//   almost_empty  count <= ae_thresh
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   clr_err       clears overflow / underflow (a same-cycle new error wins)
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int unsigned DW     = 10,
  parameter int unsigned AW     = 10,
  parameter bit          FWFT   = 1'b0,
  parameter int unsigned AF_RST = (1 << AW) - 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          w_en,
  input  logic [DW-1:0] i_dat,
  input  logic          r_en,
  output logic [DW-1:0] o_dat,
  input  logic          flush,
  input  logic [AW:0]   af_thresh,
  input  logic [AW:0]   ae_thresh,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam int unsigned  DEPTH    = 1 << AW;
  localparam logic [AW:0]  CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]  CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Storage (intentionally not reset)
  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] rptr_q,  rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q,  full_d;
  logic          empty_q, empty_d;
  logic          af_q,    af_d;
  logic          ae_q,    ae_d;
  logic          ovf_q,   ovf_d;
  logic          udf_q,   udf_d;
  logic [DW-1:0] odat_q,  odat_d;

  logic          wr_acc;
  logic          rd_acc;
  logic          ovf_set;
  logic          udf_set;

  // ---------------------------------------------------------------------------
  // Request qualification: uses the registered full/empty of this cycle, so a
  // write while full is refused even if a read frees a slot in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_acc  = w_en & ~full_q  & ~flush;
    rd_acc  = r_en & ~empty_q & ~flush;
    ovf_set = w_en &  full_q  & ~flush;
    udf_set = r_en &  empty_q & ~flush;
  end

  // ---------------------------------------------------------------------------
  // Pointer / level next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags, registered from the next-state level so they move together
  // with count; thresholds are sampled live, hence a one-cycle reaction delay.
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    af_d    = (count_d >= af_thresh);
    ae_d    = (count_d <= ae_thresh);
    ovf_d   = (ovf_q & ~clr_err) | ovf_set;
    udf_d   = (udf_q & ~clr_err) | udf_set;
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_fwft
    // o_dat tracks the head of the next state. When the next head is the word
    // being written this cycle (write into empty, or write that becomes head
    // right after the last stored word is popped) it is not in storage yet,
    // so it is taken straight from i_dat.
    always_comb begin
      odat_d = odat_q;
      if (!flush && (count_d != '0)) begin
        if (wr_acc && (wptr_q == rptr_d)) begin
          odat_d = i_dat;
        end else begin
          odat_d = mem_q[rptr_d];
        end
      end
    end
  end else begin : g_std
    always_comb begin
      odat_d = odat_q;
      if (rd_acc) begin
        odat_d = mem_q[rptr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) begin
      mem_q[wptr_q] <= i_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      odat_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      odat_q  <= odat_d;
    end
  end

  // AF_RST is a reference value only; sanity-check the configuration.
  param_range_chk: assert property (@(posedge clk) (AW >= 2) && (AF_RST <= DEPTH));

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_dat        = odat_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
module tb_sync_fifo_prog;

  localparam int unsigned DW     = 10;
  localparam int unsigned AW     = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF_RST = DEPTH - 4;

  logic          clk = 1'b0;
  logic          rstn, w_en, r_en, flush, clr_err;
  logic [DW-1:0] i_dat;
  logic [AW:0]   af_thresh, ae_thresh;

  logic [DW-1:0] o_dat0, o_dat1;
  logic [AW:0]   count0, count1;
  logic          full0, empty0, af0, ae0, ovf0, udf0;
  logic          full1, empty1, af1, ae1, ovf1, udf1;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DW(DW), .AW(AW), .FWFT(1'b0), .AF_RST(AF_RST)) u_std (
    .clk(clk), .rstn(rstn), .w_en(w_en), .i_dat(i_dat), .r_en(r_en),
    .o_dat(o_dat0), .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(udf0), .clr_err(clr_err)
  );

  sync_fifo_prog #(.DW(DW), .AW(AW), .FWFT(1'b1), .AF_RST(AF_RST)) u_fwft (
    .clk(clk), .rstn(rstn), .w_en(w_en), .i_dat(i_dat), .r_en(r_en),
    .o_dat(o_dat1), .flush(flush), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(udf1), .clr_err(clr_err)
  );

  // Reference model: a queue of stored words plus the observable flags.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf, m_af, m_ae;
  logic [DW-1:0] m_o0, m_o1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic is_full, is_empty;
    logic [DW-1:0] v;
    if (!rstn) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
      m_af  = 1'b0; m_ae  = 1'b1;
      m_o0  = '0;   m_o1  = '0;
    end else if (flush) begin
      q.delete();
      m_af = (0 >= int'(af_thresh));
      m_ae = (0 <= int'(ae_thresh));
    end else begin
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      if (r_en && !is_empty) begin
        v    = q.pop_front();
        m_o0 = v;
      end
      if (w_en && !is_full) q.push_back(i_dat);
      if (q.size() > 0) m_o1 = q[0];
      m_ovf = (m_ovf && !clr_err) || (w_en && is_full);
      m_udf = (m_udf && !clr_err) || (r_en && is_empty);
      m_af  = (q.size() >= int'(af_thresh));
      m_ae  = (q.size() <= int'(ae_thresh));
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("count_std",  32'(count0), 32'(n));
    check_eq("full_std",   32'(full0),  32'(n == DEPTH));
    check_eq("empty_std",  32'(empty0), 32'(n == 0));
    check_eq("af_std",     32'(af0),    32'(m_af));
    check_eq("ae_std",     32'(ae0),    32'(m_ae));
    check_eq("ovf_std",    32'(ovf0),   32'(m_ovf));
    check_eq("udf_std",    32'(udf0),   32'(m_udf));
    check_eq("odat_std",   32'(o_dat0), 32'(m_o0));
    check_eq("count_fwft", 32'(count1), 32'(n));
    check_eq("full_fwft",  32'(full1),  32'(n == DEPTH));
    check_eq("empty_fwft", 32'(empty1), 32'(n == 0));
    check_eq("af_fwft",    32'(af1),    32'(m_af));
    check_eq("ae_fwft",    32'(ae1),    32'(m_ae));
    check_eq("ovf_fwft",   32'(ovf1),   32'(m_ovf));
    check_eq("udf_fwft",   32'(udf1),   32'(m_udf));
    check_eq("odat_fwft",  32'(o_dat1), 32'(m_o1));
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic fl, input logic ce);
    w_en = w; i_dat = d; r_en = r; flush = fl; clr_err = ce;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int unsigned wp, rp;
    logic w, r, fl, ce;
    rstn = 1'b0; w_en = 1'b0; r_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    i_dat = '0; af_thresh = (AW+1)'(AF_RST); ae_thresh = 5'd2;

    // Reset then idle
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_odat", 32'(o_dat0), 32'h0);
    check_eq("rst_ae",   32'(ae0),    32'h1);

    // Fill to full, then one write too many
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == 12) check_eq("af_at_12", 32'(af0), 32'h1);
      if (i == 11) check_eq("af_at_11", 32'(af0), 32'h0);
    end
    check_eq("fill_full", 32'(full0), 32'h1);
    cyc(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_set",   32'(ovf0),   32'h1);
    check_eq("ovf_count", 32'(count0), 32'd16);

    // Drain in order, then one read too many
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_eq("drain_data", 32'(o_dat0), 32'(i));
    end
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("udf_set",   32'(udf0),   32'h1);
    check_eq("udf_hold",  32'(o_dat0), 32'h010);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Steady-state traffic at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(10'h100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, DW'(10'h200 + i), 1'b1, 1'b0, 1'b0);
    check_eq("steady_cnt", 32'(count0), 32'd8);
    check_eq("steady_ovf", 32'(ovf0 | udf0), 32'h0);
    repeat (8) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // FWFT write into empty, then pop
    cyc(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0);
    check_eq("fwft_head",  32'(o_dat1), 32'h2AA);
    check_eq("fwft_nempt", 32'(empty1), 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("fwft_empty", 32'(empty1), 32'h1);

    // Raise both errors, settle at level 10, flush with w_en and r_en
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1'b1, DW'(10'h300 + i), 1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("pre_flush", 32'(count0), 32'd10);
    cyc(1'b1, 10'h155, 1'b1, 1'b1, 1'b0);
    check_eq("flush_cnt", 32'(count0), 32'd0);
    check_eq("flush_err", 32'({ovf0, udf0}), 32'h3);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("clr_err",   32'({ovf0, udf0}), 32'h0);

    // Randomized traffic with biased phases so both ends are reached
    for (int c = 0; c < 1500; c++) begin
      case ((c / 100) % 3)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 60; rp = 60; end
      endcase
      if ($urandom_range(0, 29) == 0) begin
        af_thresh = (AW+1)'($urandom_range(0, 17));
        ae_thresh = (AW+1)'($urandom_range(0, 17));
      end
      rstn = ($urandom_range(0, 299) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      ce   = !fl && ($urandom_range(0, 19) == 0);
      w    = ($urandom_range(0, 99) < wp);
      r    = ($urandom_range(0, 99) < rp);
      cyc(w, DW'($urandom_range(0, 1023)), r, fl, ce);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
